uart_rx: RTL and testbench

Receive half of the DHT11 telemetry UART link. The block deserialises 8N1 frames from the asynchronous `rx` pin into bytes and holds each byte in a one-entry holding register with a full flag. It reports framing errors and overruns to the downstream command/logging logic. It runs on the same 1 MHz system clock and baud parameters as the transmit side.

---
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: groups the serial line, the consumer read strobe and the
// receive status/data outputs of uart_rx.
//   slave  - the receiver: takes rx/rx_read, drives data and status
//   master - the line/consumer side: drives rx/rx_read, observes status
interface uart_rx_if;
    logic       rx;
    logic       rx_read;
    logic [7:0] rx_data;
    logic       rx_full;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    modport slave (
        input  rx, rx_read,
        output rx_data, rx_full, rx_valid, rx_frame_err, rx_overrun, rx_busy
    );

    modport master (
        output rx, rx_read,
        input  rx_data, rx_full, rx_valid, rx_frame_err, rx_overrun, rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-entry holding register.
// Ports:
//   clk          - system clock, rising edge
//   rst_n        - asynchronous active-low reset
//   bus (slave)  - rx line in, rx_read strobe in; rx_data, rx_full,
//                  rx_valid / rx_frame_err / rx_overrun pulses, rx_busy out
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 1_000_000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave bus
);
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned BIT_PERIOD  = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_PERIOD = BIT_PERIOD / 2;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_full;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             r_busy;
    logic             w_rx_s;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // Receive FSM with bit timing, holding register and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_full      <= 1'b0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            // A read clears the flag; a good stop below in the same cycle wins
            if (bus.rx_read) begin
                r_full <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                // Re-check the line at mid start bit to reject glitches
                S_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state <= S_DATA;
                            r_idx   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_shift[r_idx] <= w_rx_s;
                        r_cnt          <= '0;
                        r_idx          <= r_idx + IDX_W'(1);
                        if (r_idx == IDX_W'(7)) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_data    <= r_shift;
                            r_valid   <= 1'b1;
                            r_full    <= 1'b1;
                            r_overrun <= r_full & ~bus.rx_read;
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                // Hold off start detection until a break releases the line
                S_WAIT_IDLE: begin
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data      = r_data;
    assign bus.rx_full      = r_full;
    assign bus.rx_valid     = r_valid;
    assign bus.rx_frame_err = r_frame_err;
    assign bus.rx_overrun   = r_overrun;
    assign bus.rx_busy      = r_busy;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. Frames are driven bit by bit
// on rx; a small holding-register model (m_data/m_full) predicts data, full
// and overrun, and latencies are checked against the nominal frame timing.
module tb_uart_rx;
    localparam int BIT = 104;   // 1 MHz / 9600 baud
    localparam int LAT = 989;   // stop sample relative to edge E
    localparam int TOL = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_rx_if bus();

    uart_rx #(
        .CLK_FREQ (1_000_000),
        .BAUD_RATE(9600)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-frame observation record; rel==0 is edge E
    int rel, n_valid, n_ferr, n_ovr, valid_at, ovr_at, busy_rise, busy_fall;
    int read_at = -1;
    int g_lat   = LAT;

    // Reference holding register
    logic [7:0] m_data;
    logic       m_full;

    task automatic clr_rec();
        rel = -1; n_valid = 0; n_ferr = 0; n_ovr = 0;
        valid_at = -1; ovr_at = -1; busy_rise = -1; busy_fall = -1;
    endtask

    // Advance one clock, drive rx_read for the requested edge, record pulses
    task automatic step();
        bus.rx_read = (read_at >= 0 && rel + 1 == read_at);
        @(posedge clk);
        #1;
        rel++;
        if (bus.rx_valid)     begin n_valid++; valid_at = rel; end
        if (bus.rx_frame_err) n_ferr++;
        if (bus.rx_overrun)   begin n_ovr++; ovr_at = rel; end
        if (bus.rx_busy && busy_rise < 0) busy_rise = rel;
        if (!bus.rx_busy && busy_rise >= 0 && busy_fall < 0) busy_fall = rel;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        logic [7:0] v;
        v = b;
        clr_rec();
        bus.rx = 1'b0;
        repeat (BIT) step();
        for (int i = 0; i < 8; i++) begin
            bus.rx = v[i];
            repeat (BIT) step();
        end
        bus.rx = stop_bit;
        repeat (BIT) step();
        bus.rx_read = 1'b0;
    endtask

    task automatic do_read();
        bus.rx_read = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_read = 1'b0;
        m_full = 1'b0;
    endtask

    task automatic test_reset();
        bus.rx = 1'b1; bus.rx_read = 1'b0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m_data = 8'h00; m_full = 1'b0;
        checks++;
        if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", bus.rx_data); end
        checks++;
        if ({bus.rx_full, bus.rx_valid, bus.rx_frame_err, bus.rx_overrun, bus.rx_busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000",
                     {bus.rx_full, bus.rx_valid, bus.rx_frame_err, bus.rx_overrun, bus.rx_busy});
        end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [7:0] pat [2];
        pat[0] = 8'h55; pat[1] = 8'hA3;
        for (int f = 0; f < 2; f++) begin
            drive_frame(pat[f], 1'b1);
            m_data = pat[f]; m_full = 1'b1;
            if (f == 0 && n_valid == 1) g_lat = valid_at;
            checks++;
            if (n_valid != 1) begin errors++; $display("FAIL basic_valid_count f%0d got %0d exp 1", f, n_valid); end
            checks++;
            if (valid_at < LAT - TOL || valid_at > LAT + TOL) begin
                errors++; $display("FAIL basic_latency f%0d got %0d exp %0d+-%0d", f, valid_at, LAT, TOL);
            end
            checks++;
            if (bus.rx_data !== m_data) begin errors++; $display("FAIL basic_data f%0d got %h exp %h", f, bus.rx_data, m_data); end
            checks++;
            if (bus.rx_full !== 1'b1) begin errors++; $display("FAIL basic_full f%0d got %b exp 1", f, bus.rx_full); end
            checks++;
            if (n_ovr != 0 || n_ferr != 0) begin
                errors++; $display("FAIL basic_no_err f%0d ovr %0d ferr %0d exp 0 0", f, n_ovr, n_ferr);
            end
            checks++;
            if (busy_rise < 2 - TOL || busy_rise > 2 + TOL) begin
                errors++; $display("FAIL basic_busy_rise f%0d got %0d exp 2+-1", f, busy_rise);
            end
            if (f == 0) begin
                do_read();
                checks++;
                if (bus.rx_full !== 1'b0) begin errors++; $display("FAIL basic_read_clear got %b exp 0", bus.rx_full); end
            end
        end
    endtask

    task automatic test_glitch();
        do_read();
        clr_rec();
        bus.rx = 1'b0;
        repeat (20) step();
        bus.rx = 1'b1;
        repeat (200) step();
        checks++;
        if (busy_rise < 2 - TOL || busy_rise > 2 + TOL) begin
            errors++; $display("FAIL glitch_start got %0d exp 2+-1", busy_rise);
        end
        checks++;
        if (busy_fall < 53 - TOL || busy_fall > 53 + TOL) begin
            errors++; $display("FAIL glitch_idle got %0d exp 53+-1", busy_fall);
        end
        checks++;
        if (n_valid + n_ferr + n_ovr != 0) begin
            errors++; $display("FAIL glitch_pulses got %0d exp 0", n_valid + n_ferr + n_ovr);
        end
        checks++;
        if (bus.rx_full !== 1'b0) begin errors++; $display("FAIL glitch_full got %b exp 0", bus.rx_full); end
    endtask

    task automatic test_frame_err();
        drive_frame(8'h3C, 1'b0);
        repeat (300) step();
        checks++;
        if (n_ferr != 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", n_ferr); end
        checks++;
        if (n_valid != 0 || n_ovr != 0) begin
            errors++; $display("FAIL ferr_no_valid valid %0d ovr %0d exp 0 0", n_valid, n_ovr);
        end
        checks++;
        if (bus.rx_data !== m_data || bus.rx_full !== m_full) begin
            errors++; $display("FAIL ferr_hold got %h/%b exp %h/%b", bus.rx_data, bus.rx_full, m_data, m_full);
        end
        checks++;
        if (bus.rx_busy !== 1'b1 || busy_fall >= 0) begin
            errors++; $display("FAIL ferr_wait_idle busy %b fall %0d exp 1 -1", bus.rx_busy, busy_fall);
        end
        bus.rx = 1'b1;
        repeat (20) step();
        checks++;
        if (bus.rx_busy !== 1'b0 || n_valid != 0 || n_ferr != 1) begin
            errors++; $display("FAIL ferr_release busy %b valid %0d ferr %0d exp 0 0 1", bus.rx_busy, n_valid, n_ferr);
        end
    endtask

    task automatic test_overrun();
        do_read();
        drive_frame(8'h11, 1'b1);
        m_data = 8'h11; m_full = 1'b1;
        drive_frame(8'h22, 1'b1);
        m_data = 8'h22;
        checks++;
        if (n_ovr != 1 || n_valid != 1 || ovr_at != valid_at) begin
            errors++; $display("FAIL ovr_pulse ovr %0d@%0d valid %0d@%0d exp 1 with valid", n_ovr, ovr_at, n_valid, valid_at);
        end
        checks++;
        if (bus.rx_data !== m_data || bus.rx_full !== 1'b1) begin
            errors++; $display("FAIL ovr_state got %h/%b exp %h/1", bus.rx_data, bus.rx_full, m_data);
        end
    endtask

    task automatic test_read_on_stop();
        do_read();
        drive_frame(8'h11, 1'b1);
        m_data = 8'h11; m_full = 1'b1;
        read_at = g_lat;
        drive_frame(8'h22, 1'b1);
        read_at = -1;
        m_data = 8'h22;
        checks++;
        if (n_ovr != 0 || n_valid != 1) begin
            errors++; $display("FAIL rdstop_pulses ovr %0d valid %0d exp 0 1", n_ovr, n_valid);
        end
        checks++;
        if (bus.rx_full !== 1'b1 || bus.rx_data !== m_data) begin
            errors++; $display("FAIL rdstop_state got %b/%h exp 1/%h", bus.rx_full, bus.rx_data, m_data);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        v = 8'hF0;
        do_read();
        clr_rec();
        bus.rx = 1'b0;
        repeat (BIT) step();
        for (int i = 0; i < 4; i++) begin
            bus.rx = v[i];
            repeat (BIT) step();
        end
        bus.rx = v[4];
        repeat (BIT / 2) step();
        #2 rst_n = 1'b0;
        #1;
        m_data = 8'h00; m_full = 1'b0;
        checks++;
        if ({bus.rx_data, bus.rx_full, bus.rx_valid, bus.rx_frame_err, bus.rx_overrun, bus.rx_busy} !== 13'h0) begin
            errors++; $display("FAIL rstmid_async data %h full %b busy %b exp 00 0 0", bus.rx_data, bus.rx_full, bus.rx_busy);
        end
        repeat (3) step();
        bus.rx = 1'b1;
        rst_n  = 1'b1;
        repeat (BIT * 6) step();
        checks++;
        if (n_valid + n_ferr + n_ovr != 0) begin
            errors++; $display("FAIL rstmid_pulses got %0d exp 0", n_valid + n_ferr + n_ovr);
        end
        drive_frame(8'h7E, 1'b1);
        m_data = 8'h7E; m_full = 1'b1;
        checks++;
        if (n_valid != 1 || bus.rx_data !== m_data || bus.rx_full !== 1'b1) begin
            errors++; $display("FAIL rstmid_recover valid %0d data %h full %b exp 1 %h 1", n_valid, bus.rx_data, bus.rx_full, m_data);
        end
    endtask

    // Back-to-back random bytes with randomly placed reads
    task automatic test_back_to_back();
        for (int f = 0; f < 8; f++) begin
            logic [7:0] b;
            int         mode;
            logic       exp_ovr;
            b    = 8'($urandom_range(0, 255));
            mode = int'($urandom_range(0, 2));
            if (mode == 1) do_read();
            read_at = (mode == 2) ? g_lat : -1;
            exp_ovr = m_full && (mode != 2);
            drive_frame(b, 1'b1);
            read_at = -1;
            m_data = b; m_full = 1'b1;
            checks++;
            if (n_valid != 1 || bus.rx_data !== m_data) begin
                errors++; $display("FAIL b2b_data f%0d valid %0d got %h exp %h", f, n_valid, bus.rx_data, m_data);
            end
            checks++;
            if (n_ovr != int'(exp_ovr)) begin
                errors++; $display("FAIL b2b_overrun f%0d mode %0d got %0d exp %0d", f, mode, n_ovr, exp_ovr);
            end
            checks++;
            if (bus.rx_full !== m_full || n_ferr != 0) begin
                errors++; $display("FAIL b2b_full f%0d got %b ferr %0d exp %b 0", f, bus.rx_full, n_ferr, m_full);
            end
            checks++;
            if (valid_at < LAT - TOL || valid_at > LAT + TOL) begin
                errors++; $display("FAIL b2b_latency f%0d got %0d exp %0d+-%0d", f, valid_at, LAT, TOL);
            end
        end
    endtask

    initial begin
        bus.rx      = 1'b1;
        bus.rx_read = 1'b0;
        clr_rec();
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_read_on_stop();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
